stream_pkt_source: RTL and testbench

- Valid-ready stream transmitter: on a start command, emits a packet of len beats of generated pattern data on a write-side valid/ready interface.
- Drives the write port of our stream pipe registers and FIFOs.
- Used as the traffic initiator in block-level benches and in on-chip loopback/self-test paths.
- Honours backpressure, supports programmable inter-beat gaps, and flags the final beat.

---
 rtl/stream_pkt_source.sv | 157 +++++++++++++++
 tb/tb_stream_pkt_source.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/stream_pkt_source.sv
// stream_pkt_source: valid/ready packet generator.
// On an accepted start it presents len beats of pattern data (incrementing
// or alternating seed/~seed), optionally separated by gap idle cycles, and
// flags the final beat with wlast. All outputs come straight from flops.
//
// Handshake: a beat moves on a rising clk edge where wvalid & wready are
// both high. Once wvalid is raised, wvalid/wdata/wlast hold until that
// edge, and wvalid is never a function of wready.
module stream_pkt_source #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int GAP_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  mode,
  input  logic [GAP_WIDTH-1:0]  gap,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  output logic                  wlast,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  sent_cnt,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0] GAP_ONE = GAP_WIDTH'(1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wvalid_q, wvalid_d;
  logic                  wlast_q, wlast_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [LEN_WIDTH-1:0]  sent_q, sent_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  mode_q, mode_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d;
  logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;

  // Register all state and outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wdata_q   <= '0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sent_q    <= '0;
      len_q     <= '0;
      mode_q    <= 1'b0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wdata_q   <= wdata_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sent_q    <= sent_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Next-state and next-output logic; everything holds unless changed.
  always_comb begin
    state_d   = state_q;
    wdata_d   = wdata_q;
    wvalid_d  = wvalid_q;
    wlast_d   = wlast_q;
    done_d    = 1'b0;
    sent_d    = sent_q;
    len_d     = len_q;
    mode_d    = mode_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sent_d = '0;
          if (len != '0) begin
            state_d  = S_SEND;
            len_d    = len;
            mode_d   = mode;
            gap_d    = gap;
            wdata_d  = seed;
            wvalid_d = 1'b1;
            wlast_d  = (len == LEN_ONE);
          end else begin
            // Empty packet: nothing to send, just report completion.
            done_d = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (wready) begin
          sent_d = sent_q + LEN_ONE;
          if (wlast_q) begin
            state_d  = S_IDLE;
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            done_d   = 1'b1;
          end else begin
            // Alternating mode just flips the previous beat.
            wdata_d = mode_q ? ~wdata_q : wdata_q + DATA_WIDTH'(1);
            wlast_d = ((sent_q + LEN_ONE) == (len_q - LEN_ONE));
            if (gap_q != '0) begin
              state_d   = S_GAP;
              gap_cnt_d = gap_q;
              wvalid_d  = 1'b0;
            end
          end
        end
      end
      S_GAP: begin
        // Counter starts at gap and releases on 1, giving exactly gap idle cycles.
        if (gap_cnt_q == GAP_ONE) begin
          state_d  = S_SEND;
          wvalid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        wvalid_d = 1'b0;
        wlast_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign wdata     = wdata_q;
  assign wvalid    = wvalid_q;
  assign wlast     = wlast_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sent_cnt  = sent_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stream_pkt_source.sv
// Directed bench for stream_pkt_source: inputs are driven and outputs
// sampled on the falling clock edge, away from the active rising edge.
module tb_stream_pkt_source;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic [7:0] seed;
  logic       mode;
  logic [3:0] gap;
  logic [7:0] wdata;
  logic       wvalid;
  logic       wready;
  logic       wlast;
  logic       busy;
  logic       done;
  logic [7:0] sent_cnt;
  logic [1:0] dbg_state;

  int tests;
  int failed;
  logic [7:0] exp_q[$];

  stream_pkt_source #(.DATA_WIDTH(8), .LEN_WIDTH(8), .GAP_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .seed(seed), .mode(mode),
    .gap(gap), .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .busy(busy), .done(done), .sent_cnt(sent_cnt), .dbg_state(dbg_state)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge after it was sampled.
  task automatic do_start(input logic [7:0] l, input logic [7:0] s, input logic m, input logic [3:0] g);
    len = l; seed = s; mode = m; gap = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for the next beat, check its gap, data and last flag,
  // optionally stall it with wready low, then let it transfer.
  task automatic beat(input string tag, input logic [7:0] exp_d, input logic exp_l,
                      input int exp_gap, input int stall, input logic next_ready);
    int n;
    n = 0;
    while (!wvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, wvalid, 1'b1);
    if (exp_gap >= 0) check({tag, "_gap"}, n, exp_gap);
    check({tag, "_data"}, wdata, exp_d);
    check({tag, "_last"}, wlast, exp_l);
    check({tag, "_busy"}, busy, 1'b1);
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check({tag, "_stall_valid"}, wvalid, 1'b1);
        check({tag, "_stall_data"}, wdata, exp_d);
        check({tag, "_stall_last"}, wlast, exp_l);
      end
      wready = 1'b1;
    end
    @(posedge clk);
    #1 wready = next_ready;
    @(negedge clk);
  endtask

  // Checks the completion cycle right after the final handshake.
  task automatic check_done(input string tag, input logic [7:0] exp_cnt);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_done_valid"}, wvalid, 1'b0);
    check({tag, "_done_last"}, wlast, 1'b0);
    check({tag, "_done_busy"}, busy, 1'b0);
    check({tag, "_done_cnt"}, sent_cnt, exp_cnt);
    @(negedge clk);
    check({tag, "_done_drop"}, done, 1'b0);
    check({tag, "_cnt_hold"}, sent_cnt, exp_cnt);
  endtask

  initial begin
    logic [7:0] d;
    logic       rdy;
    int         st;
    tests = 0; failed = 0;
    rst = 1'b0; start = 1'b0; len = '0; seed = '0; mode = 1'b0; gap = '0; wready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_wdata", wdata, 8'h00);
    check("rst_wlast", wlast, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cnt", sent_cnt, 8'h00);
    rst = 1'b1;
    @(negedge clk);

    // 1: len 4, incrementing from FE, back-to-back
    do_start(8'd4, 8'hFE, 1'b0, 4'd0);
    beat("t1_b0", 8'hFE, 1'b0, 0, 0, 1'b1);
    beat("t1_b1", 8'hFF, 1'b0, 0, 0, 1'b1);
    beat("t1_b2", 8'h00, 1'b0, 0, 0, 1'b1);
    beat("t1_b3", 8'h01, 1'b1, 0, 0, 1'b1);
    check_done("t1", 8'd4);

    // 2: same packet, beat 1 held off for 3 cycles
    do_start(8'd4, 8'hFE, 1'b0, 4'd0);
    beat("t2_b0", 8'hFE, 1'b0, 0, 0, 1'b0);
    beat("t2_b1", 8'hFF, 1'b0, 0, 3, 1'b1);
    beat("t2_b2", 8'h00, 1'b0, 0, 0, 1'b1);
    beat("t2_b3", 8'h01, 1'b1, 0, 0, 1'b1);
    check_done("t2", 8'd4);

    // 3: alternating pattern with two idle cycles between beats
    do_start(8'd3, 8'hA5, 1'b1, 4'd2);
    beat("t3_b0", 8'hA5, 1'b0, 0, 0, 1'b1);
    beat("t3_b1", 8'h5A, 1'b0, 2, 0, 1'b1);
    beat("t3_b2", 8'hA5, 1'b1, 2, 0, 1'b1);
    check_done("t3", 8'd3);

    // 4: empty packet
    do_start(8'd0, 8'h33, 1'b0, 4'd0);
    check("t4_valid", wvalid, 1'b0);
    check("t4_busy", busy, 1'b0);
    check("t4_done", done, 1'b1);
    check("t4_cnt", sent_cnt, 8'd0);
    @(negedge clk);
    check("t4_done_drop", done, 1'b0);
    check("t4_valid2", wvalid, 1'b0);

    // 5a: start pulsed mid-packet is ignored
    do_start(8'd3, 8'h10, 1'b0, 4'd1);
    beat("t5_b0", 8'h10, 1'b0, 0, 0, 1'b1);
    check("t5_gap_busy", busy, 1'b1);
    len = 8'd1; seed = 8'h99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    beat("t5_b1", 8'h11, 1'b0, -1, 0, 1'b1);
    beat("t5_b2", 8'h12, 1'b1, 1, 0, 1'b1);
    check_done("t5", 8'd3);

    // 5b: asynchronous reset during beat 2 of a len-5 packet
    do_start(8'd5, 8'h40, 1'b0, 4'd0);
    beat("t5r_b0", 8'h40, 1'b0, 0, 0, 1'b1);
    beat("t5r_b1", 8'h41, 1'b0, 0, 0, 1'b1);
    check("t5r_b2_data", wdata, 8'h42);
    #2 rst = 1'b0;
    #1;
    check("t5r_wvalid", wvalid, 1'b0);
    check("t5r_wdata", wdata, 8'h00);
    check("t5r_wlast", wlast, 1'b0);
    check("t5r_busy", busy, 1'b0);
    check("t5r_done", done, 1'b0);
    check("t5r_cnt", sent_cnt, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_start(8'd2, 8'h80, 1'b1, 4'd0);
    beat("t5n_b0", 8'h80, 1'b0, 0, 0, 1'b1);
    beat("t5n_b1", 8'h7F, 1'b1, 0, 0, 1'b1);
    check_done("t5n", 8'd2);

    // 6: 200 beats under random backpressure
    for (int i = 0; i < 200; i++) exp_q.push_back(8'h37 + 8'(i));
    do_start(8'd200, 8'h37, 1'b0, 4'd0);
    for (int i = 0; i < 200; i++) begin
      d = exp_q.pop_front();
      rdy = 1'($urandom_range(0, 1));
      st = (!wready) ? int'($urandom_range(1, 3)) : 0;
      beat("t6_beat", d, (i == 199), -1, st, rdy);
    end
    check("t6_queue_empty", exp_q.size(), 0);
    check_done("t6", 8'd200);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
